// File: rtl/key_conditioner.sv
// key_conditioner: synchronises active-low push-button lines and debounces each
// key independently. Produces clean held levels plus registered one-cycle
// press, release and long-press pulses.
//
// state             | meaning
// ------------------+---------------------------------------------------------
// S_RELEASED        | key idle, waiting for synchronised press
// S_CONFIRM_PRESS   | press seen, counting stable cycles before accepting it
// S_HELD            | press accepted, counting towards long-press
// S_LONG            | long-press already reported for this hold
// S_CONFIRM_RELEASE | release seen, counting stable cycles; hold count frozen
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int CNT_W           = 26
) (
  input  logic              clk_50a_i,
  input  logic              reset_i,
  input  logic [N_KEYS-1:0] key_n_i,
  output logic [N_KEYS-1:0] held_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o,
  output logic [N_KEYS-1:0] long_press_o,
  output logic              any_held_o
);

  typedef enum logic [2:0] {
    S_RELEASED,
    S_CONFIRM_PRESS,
    S_HELD,
    S_LONG,
    S_CONFIRM_RELEASE
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  state_e            state_q   [N_KEYS];
  state_e            state_d   [N_KEYS];
  logic [CNT_W-1:0]  dcnt_q    [N_KEYS];
  logic [CNT_W-1:0]  dcnt_d    [N_KEYS];
  logic [CNT_W-1:0]  hcnt_q    [N_KEYS];
  logic [CNT_W-1:0]  hcnt_d    [N_KEYS];
  logic [N_KEYS-1:0] long_done_q, long_done_d;
  logic [N_KEYS-1:0] held_q, held_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] long_q, long_d;
  logic              any_held_q;

  // Per-key next-state, counter and pulse logic; s = sync2_q (1 = pressed).
  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      state_d[k]     = state_q[k];
      dcnt_d[k]      = dcnt_q[k];
      hcnt_d[k]      = hcnt_q[k];
      long_done_d[k] = long_done_q[k];
      press_d[k]     = 1'b0;
      release_d[k]   = 1'b0;
      long_d[k]      = 1'b0;
      case (state_q[k])
        S_RELEASED: begin
          if (sync2_q[k]) begin
            state_d[k] = S_CONFIRM_PRESS;
            dcnt_d[k]  = '0;
          end
        end
        S_CONFIRM_PRESS: begin
          if (!sync2_q[k]) begin
            state_d[k] = S_RELEASED;
          end else if (dcnt_q[k] == DEB_LAST) begin
            state_d[k]     = S_HELD;
            press_d[k]     = 1'b1;
            hcnt_d[k]      = '0;
            long_done_d[k] = 1'b0;
          end else begin
            dcnt_d[k] = dcnt_q[k] + CNT_ONE;
          end
        end
        S_HELD: begin
          if (!sync2_q[k]) begin
            state_d[k] = S_CONFIRM_RELEASE;
            dcnt_d[k]  = '0;
          end else if (hcnt_q[k] == LONG_LAST) begin
            state_d[k]     = S_LONG;
            long_d[k]      = 1'b1;
            long_done_d[k] = 1'b1;
          end else begin
            hcnt_d[k] = hcnt_q[k] + CNT_ONE;
          end
        end
        S_LONG: begin
          if (!sync2_q[k]) begin
            state_d[k] = S_CONFIRM_RELEASE;
            dcnt_d[k]  = '0;
          end
        end
        S_CONFIRM_RELEASE: begin
          if (sync2_q[k]) begin
            state_d[k] = long_done_q[k] ? S_LONG : S_HELD;
          end else if (dcnt_q[k] == DEB_LAST) begin
            state_d[k]   = S_RELEASED;
            release_d[k] = 1'b1;
          end else begin
            dcnt_d[k] = dcnt_q[k] + CNT_ONE;
          end
        end
        default: state_d[k] = S_RELEASED;
      endcase
      held_d[k] = (state_d[k] == S_HELD) || (state_d[k] == S_LONG) ||
                  (state_d[k] == S_CONFIRM_RELEASE);
    end
  end

  // Synchroniser, per-key state and registered outputs; reset wins over any pulse.
  always_ff @(posedge clk_50a_i) begin
    if (reset_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      long_done_q <= '0;
      held_q      <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      any_held_q  <= 1'b0;
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= S_RELEASED;
        dcnt_q[k]  <= '0;
        hcnt_q[k]  <= '0;
      end
    end else begin
      sync1_q     <= ~key_n_i;
      sync2_q     <= sync1_q;
      long_done_q <= long_done_d;
      held_q      <= held_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      any_held_q  <= |held_d;
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= state_d[k];
        dcnt_q[k]  <= dcnt_d[k];
        hcnt_q[k]  <= hcnt_d[k];
      end
    end
  end

  assign held_o       = held_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;
  assign any_held_o   = any_held_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short debounce/long-press times.
module tb_key_conditioner;

  localparam int NK = 4;
  localparam int D  = 4;
  localparam int L  = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] held, press, rel, lp;
  logic          any_held;

  key_conditioner #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .CNT_W(8)
  ) dut (
    .clk_50a_i(clk), .reset_i(reset), .key_n_i(key_n),
    .held_o(held), .press_o(press), .release_o(rel),
    .long_press_o(lp), .any_held_o(any_held)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Expected output word: {held, press, release, long_press, any_held}
  logic [4*NK:0] exp_q[$];

  // Reference model state: delay line for the synchroniser, then per key the
  // accepted level, the length of the current disagreement run, and how many
  // settled pressed cycles have accumulated since the press was accepted.
  logic [NK-1:0] sy1, sy2, s_m;
  logic [NK-1:0] m_lvl, m_ld;
  int            m_run [NK];
  int            m_hc  [NK];
  logic [NK-1:0] eh, ep, er, el;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      sy1 = '0; sy2 = '0; m_lvl = '0; m_ld = '0;
      for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_hc[k] = 0; end
      exp_q.push_back('0);
    end else begin
      s_m = sy2; sy2 = sy1; sy1 = ~key_n;
      ep = '0; er = '0; el = '0;
      for (int k = 0; k < NK; k++) begin
        if (s_m[k] != m_lvl[k]) begin
          // a level change is accepted after D+1 consecutive disagreeing samples
          m_run[k]++;
          if (m_run[k] == D + 1) begin
            m_lvl[k] = s_m[k];
            m_run[k] = 0;
            if (s_m[k]) begin ep[k] = 1'b1; m_hc[k] = 0; m_ld[k] = 1'b0; end
            else er[k] = 1'b1;
          end
        end else begin
          // a cycle ending a release bounce does not add to the hold time
          if (m_lvl[k] && m_run[k] == 0 && !m_ld[k]) begin
            m_hc[k]++;
            if (m_hc[k] == L) begin el[k] = 1'b1; m_ld[k] = 1'b1; end
          end
          m_run[k] = 0;
        end
      end
      eh = m_lvl;
      exp_q.push_back({eh, ep, er, el, |eh});
    end
  end

  // Event log used by the directed timing checks.
  int n_press [NK], n_rel [NK], n_long [NK];
  int last_press [NK], last_rel [NK], last_long [NK];
  initial for (int k = 0; k < NK; k++) begin
    n_press[k] = 0; n_rel[k] = 0; n_long[k] = 0;
    last_press[k] = -1; last_rel[k] = -1; last_long[k] = -1;
  end

  // Monitor: every cycle the DUT presents an output word; compare with the queue.
  logic [4*NK:0] exp_w, act_w;
  always @(negedge clk) begin
    if (exp_q.size() > 1) begin
      miscompares++;
      $display("FAIL queue_overrun cyc=%0d depth=%0d required<=1", cyc, exp_q.size());
    end
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      act_w = {held, press, rel, lp, any_held};
      vectors++;
      if (act_w !== exp_w) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d got h=%b p=%b r=%b l=%b a=%b required h=%b p=%b r=%b l=%b a=%b",
                 cyc, held, press, rel, lp, any_held,
                 exp_w[4*NK:3*NK+1], exp_w[3*NK:2*NK+1], exp_w[2*NK:NK+1], exp_w[NK:1], exp_w[0]);
      end
    end
    for (int k = 0; k < NK; k++) begin
      if (press[k] === 1'b1) begin n_press[k]++; last_press[k] = cyc; end
      if (rel[k]   === 1'b1) begin n_rel[k]++;   last_rel[k]   = cyc; end
      if (lp[k]    === 1'b1) begin n_long[k]++;  last_long[k]  = cyc; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  int t0, t1, snap, snap2;
  int rem [NK];

  initial begin
    reset = 1'b1;
    key_n = '1;
    tick(3);
    reset = 1'b0;
    tick(5);

    // clean press / hold / release on key 0
    snap = n_long[0];
    t0 = cyc; key_n[0] = 1'b0; tick(30);
    t1 = cyc; key_n[0] = 1'b1; tick(12);
    check("press0_time", last_press[0], t0 + 3 + D);
    check("long0_time", last_long[0], t0 + 3 + D + L);
    check("long0_count", n_long[0] - snap, 1);
    check("release0_time", last_rel[0], t1 + 3 + D);

    // bounce rejection on key 1: short glitch ignored, minimum accepted pulse
    snap = n_press[1];
    key_n[1] = 1'b0; tick(3); key_n[1] = 1'b1; tick(10);
    check("glitch1_no_press", n_press[1] - snap, 0);
    t0 = cyc; key_n[1] = 1'b0; tick(D + 1); key_n[1] = 1'b1; tick(15);
    check("min_pulse1_press", last_press[1], t0 + 3 + D);
    check("min_pulse1_release", n_rel[1], 1);

    // release bounce on key 2 during a long hold
    snap = n_rel[2]; snap2 = n_long[2];
    key_n[2] = 1'b0; tick(40);
    key_n[2] = 1'b1; tick(2);
    key_n[2] = 1'b0; tick(30);
    check("bounce2_no_release", n_rel[2] - snap, 0);
    check("bounce2_one_long", n_long[2] - snap2, 1);
    key_n[2] = 1'b1; tick(12);

    // all keys pressed together
    t0 = cyc; key_n = '0; tick(10);
    for (int k = 0; k < NK; k++) check("simul_press", last_press[k], t0 + 3 + D);
    key_n = '1; tick(12);

    // reset while key 3 sits in the long state
    key_n[3] = 1'b0; tick(30);
    t0 = cyc; reset = 1'b1; tick(1); reset = 1'b0;
    tick(35);
    check("rst3_press", last_press[3], t0 + 1 + D + 3);
    check("rst3_long", last_long[3], t0 + 1 + D + 3 + L);
    key_n[3] = 1'b1; tick(12);

    // randomized bouncy keys with occasional resets
    for (int k = 0; k < NK; k++) rem[k] = int'($urandom_range(1, 30));
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (rem[k] == 0) begin
          key_n[k] = ~key_n[k];
          rem[k] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 7))
                                               : int'($urandom_range(8, 40));
        end else begin
          rem[k]--;
        end
      end
      reset = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    reset = 1'b0;
    key_n = '1;
    tick(15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
